// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding, default memory geometry and header width.
package imem_loader_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned HDR_W      = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // A header larger than the memory depth cannot be loaded.
    function automatic logic hdr_too_big(input logic [HDR_W-1:0] n, input int unsigned addr_w);
        return 32'(n) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes MSB-first into one 32-bit instruction word.
// word_ready_c flags the accept cycle that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_ready_c
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (shift_en) begin
            word <= {word[WORD_W-BYTE_W-1:0], data};
            cnt  <= cnt + 2'd1;
        end
    end

    assign word_ready_c = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory
// writes and holds the processor in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    logic [BYTE_W-1:0] len_hi;
    logic [CNT_W-1:0]  len;
    logic [ADDR_W-1:0] index;
    logic [HDR_W-1:0]  hdr;
    logic              fire;
    logic              shift_en;
    logic              word_ready_c;

    assign hdr       = {len_hi, in_data};
    assign in_ready  = !rst && (state == ST_LEN_HI || state == ST_LEN_LO || state == ST_DATA);
    assign fire      = in_valid && in_ready;
    assign shift_en  = fire && (state == ST_DATA);
    assign imem_addr = index;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .shift_en     (shift_en),
        .data         (in_data),
        .word         (imem_wdata),
        .word_ready_c (word_ready_c)
    );

    // Loader FSM; status outputs are registered against the destination state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            index        <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_LEN_HI: begin
                    if (fire) begin
                        len_hi <= in_data;
                        busy   <= 1'b1;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (fire) begin
                        if (hdr == '0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                            state   <= ST_DONE;
                        end else if (hdr_too_big(hdr, ADDR_W)) begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            len   <= CNT_W'(hdr);
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_ready_c) begin
                        imem_we <= 1'b1;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The index wraps only after the final word, so it is never reused.
                    index        <= index + ADDR_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                    if (words_loaded + CNT_W'(1) == len) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DONE: state <= ST_DONE;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level model
// that derives expected memory writes directly from the byte image.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                exp_words;
    bit                exp_done;
    bit                exp_err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Record every memory write seen on the bus.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
    end

    // Expected writes: word i of the image lands at address i; oversize headers write nothing.
    task automatic model(input bq_t img);
        int n;
        int full;
        exp_addr.delete();
        exp_data.delete();
        n = {img[0], img[1]};
        if (n > DEPTH) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_words = 0;
            return;
        end
        exp_err = 1'b0;
        full = (img.size() - 2) / 4;
        if (full > n) full = n;
        for (int i = 0; i < full; i++) begin
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back({img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
        end
        exp_words = full;
        exp_done  = (full == n);
    endtask

    task automatic make_image(input int n_hdr, input int n_words, output bq_t img);
        img = {};
        img.push_back(8'(n_hdr >> 8));
        img.push_back(8'(n_hdr));
        for (int i = 0; i < 4 * n_words; i++) img.push_back(8'($urandom));
    endtask

    // Present one byte (after an optional idle gap) and return on the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_byte: in_ready stuck low for byte %h (in_ready=%b, required 1)", b, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_image(input bq_t img, input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++)
            send_byte(img[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        checks++;
        if ({in_ready, imem_we, cpu_rst, busy, done, err} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 001000", {in_ready, imem_we, cpu_rst, busy, done, err});
        end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== '0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h wdata=%h words=%0d, required 0/0/0", imem_addr, imem_wdata, words_loaded);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        bq_t img;
        img = {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
        do_reset();
        model(img);
        send_image(img, 0, img.size(), 0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== ADDR_W'(1) || imem_wdata !== 32'h8C220004 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_last_write: we=%b addr=%0d data=%h rdy=%b done=%b, required 1/1/8c220004/0/0",
                     imem_we, imem_addr, imem_wdata, in_ready, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 11'd2) begin
            errors++;
            $display("FAIL basic_done: done=%b cpu_rst=%b busy=%b rdy=%b words=%0d, required 1/0/0/0/2",
                     done, cpu_rst, busy, in_ready, words_loaded);
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL basic_count: %0d writes, required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL basic_write%0d: %0d:%h, required %0d:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%b cpu_rst=%b busy=%b rdy=%b, required 1/0/0/0", done, cpu_rst, busy, in_ready);
        end
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs_addr.size() != 0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL empty_writes: %0d writes words=%0d, required 0/0", obs_addr.size(), words_loaded);
        end
    endtask

    task automatic test_err();
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        checks++;
        if (err !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_flags: err=%b cpu_rst=%b rdy=%b busy=%b done=%b, required 1/1/0/0/0",
                     err, cpu_rst, in_ready, busy, done);
        end
        in_data = 8'hA5;
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || err !== 1'b1 || obs_addr.size() != 0) begin
            errors++;
            $display("FAIL err_hold: rdy=%b err=%b writes=%0d, required 0/1/0", in_ready, err, obs_addr.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_max_len();
        bq_t img;
        make_image(DEPTH, DEPTH, img);
        do_reset();
        model(img);
        send_image(img, 0, 2, 0);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_header: busy=%b err=%b rdy=%b, required 1/0/1", busy, err, in_ready);
        end
        send_image(img, 2, img.size(), 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== exp_done || int'(words_loaded) != exp_words || obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL max_end: done=%b words=%0d writes=%0d, required %b/%0d/%0d",
                     done, words_loaded, obs_addr.size(), exp_done, exp_words, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL max_write%0d: %0d:%h, required %0d:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        bq_t img;
        for (int r = 0; r < 3; r++) begin
            make_image(3, 3, img);
            do_reset();
            model(img);
            send_image(img, 0, img.size(), 7);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 11'd3 || obs_addr.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL gaps%0d_end: done=%b cpu_rst=%b words=%0d writes=%0d, required 1/0/3/%0d",
                         r, done, cpu_rst, words_loaded, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL gaps%0d_write%0d: %0d:%h, required %0d:%h", r, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        bq_t img1;
        bq_t img2;
        int cuts[2] = '{6, 4};
        foreach (cuts[c]) begin
            make_image(2, 2, img1);
            make_image(1, 1, img2);
            do_reset();
            send_image(img1, 0, cuts[c], 0);
            rst = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            checks++;
            if (words_loaded !== '0 || busy !== 1'b0 || imem_wdata !== '0 || imem_addr !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst%0d_clear: words=%0d busy=%b wdata=%h addr=%0d rdy=%b, required 0/0/0/0/1",
                         cuts[c], words_loaded, busy, imem_wdata, imem_addr, in_ready);
            end
            obs_addr.delete();
            obs_data.delete();
            model(img2);
            send_image(img2, 0, img2.size(), 3);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if (obs_addr.size() != 1 || words_loaded !== 11'd1 || done !== 1'b1) begin
                errors++;
                $display("FAIL midrst%0d_end: writes=%0d words=%0d done=%b, required 1/1/1", cuts[c], obs_addr.size(), words_loaded, done);
            end else begin
                checks++;
                if (obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
                    errors++;
                    $display("FAIL midrst%0d_write: %0d:%h, required %0d:%h", cuts[c], obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        test_reset();
        test_basic();
        test_empty();
        test_err();
        test_max_len();
        test_random_gaps();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the KGP-RISC instruction memory from a byte stream and releases the processor once the image is complete. It sits between an external byte source (UART receiver or testbench) and the write port of the instruction memory, and drives the processor's reset. It is the write side of the instruction-memory interface the processor reads at fetch time.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the byte on `in_data` is valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: the loader accepts a byte this cycle. Transfer occurs when `in_valid` and `in_ready` are both high.
- `imem_we`  out  1: instruction-memory write enable, one-cycle pulse per word.
- `imem_addr`  out  ADDR_W: word address for the write.
- `imem_wdata`  out  32: instruction word.
- `cpu_rst`  out  1: processor reset; high until the load completes.
- `busy`  out  1: a load is in progress.
- `done`  out  1: the image is fully written.
- `err`  out  1: the length header is out of range.
- `words_loaded`  out  ADDR_W+1: count of words written so far.

## Operation
- Stream format: a 16-bit big-endian word count N (2 bytes), followed by N×4 instruction bytes. Each instruction is sent MSB first.
- States and their behaviour:
  - LEN_HI: `in_ready`=1. On transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: `in_ready`=1. On transfer, latch N[7:0], then:
    - N==0 → DONE
    - N>2^ADDR_W → ERR
    - otherwise → DATA
  - DATA: `in_ready`=1. Shift the accepted byte into `imem_wdata` (`wdata <= {wdata[23:0], byte}`) and increment the 2-bit byte counter. On the 4th byte, go to WRITE.
  - WRITE: `in_ready`=0 and `imem_we`=1. `imem_addr` equals the current word index. Next cycle, increment the index and `words_loaded`. If the new count equals N → DONE, else → DATA.
  - DONE: `in_ready`=0, `done`=1, `cpu_rst`=0. The loader stays here until `rst`.
  - ERR: `in_ready`=0, `err`=1, `cpu_rst`=1. The loader stays here until `rst`.
- `busy`=1 in LEN_LO, DATA and WRITE only.
- `cpu_rst`=1 in every state except DONE.
- `imem_we` is asserted only in WRITE. It is never asserted for a partial word.
- `in_valid` is ignored whenever `in_ready`=0. The source must hold the byte until it is accepted.
- Word index is ADDR_W bits wide. With N==2^ADDR_W, the last write goes to address 2^ADDR_W−1 and the index is never reused.

## Timing
- Reset values:
  - state LEN_HI
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_rst`=1, `busy`=0, `done`=0, `err`=0, `words_loaded`=0
  - `in_ready` is forced to 0 while `rst` is high.
- Latency:
  - 4th byte of a word accepted in cycle t → `imem_we` high in cycle t+1.
  - If that was the last word: `done`=1 and `cpu_rst`=0 in cycle t+2.
- Throughput: at most one word every 5 cycles (4 accept cycles + 1 WRITE cycle).
- Timing of `in_ready`:
  - Combinational from state, so the source sees it in the same cycle.
  - Goes low in the cycle after the 4th byte is accepted.
- Reset mid-load: the next cycle is in LEN_HI with all counters cleared. Memory contents are not erased. A partially assembled word is discarded.
- Header boundaries: N=2^ADDR_W is legal; N=2^ADDR_W+1 → ERR.

## Structure
- A shared package/header holds:
  - state encodings (LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR)
  - the default `ADDR_W`
  - the 16-bit header-width constant
- One sub-module, `byte_packer`: a 4-byte shift register with a 2-bit counter and a `word_ready` flag, cleared by `rst`.
- The top level holds the FSM, the length register, the word index and the output decode.

## Test plan
- Bytes 00 02 | 20 01 00 05 | 8C 22 00 04 with `in_valid` held high:
  - writes 0x20010005 at address 0 and 0x8C220004 at address 1
  - `done`=1 and `cpu_rst`=0 two cycles after the last byte
  - `words_loaded`=2
- Header 00 00 → DONE one cycle after the 2nd byte, with no `imem_we` pulse.
- Header 04 01 with ADDR_W=10 (N=1025) → `err`=1, `cpu_rst` stays 1, `in_ready`=0. Header 04 00 is accepted.
- Random `in_valid` gaps (0–7 idle cycles) during a 3-word load → identical writes and addresses. No byte is lost or duplicated.
- `rst` pulsed after 6 bytes of a 2-word image, then a fresh 1-word image → a single write at address 0 with the new data, `words_loaded`=1.
- `in_valid` held high during WRITE, DONE and ERR → no transfer occurs, and the next byte is accepted only when `in_ready` returns to 1.
